// File: rtl/alloc_pkg.sv
// Shared types for the switch-allocation requester: destination index type,
// per-input requester state and a one-hot helper.
package alloc_pkg;

    localparam int unsigned N_DEF  = 4;
    localparam int unsigned DEST_W = $clog2(N_DEF);

    typedef logic [DEST_W-1:0] dest_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_REQ,
        ST_HOLD
    } req_state_t;

    function automatic logic [N_DEF-1:0] onehot(input dest_t d);
        logic [N_DEF-1:0] v;
        v    = '0;
        v[d] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Destination-index FIFO for one allocator input. The caller guarantees
// push only when not full and pop only when not empty.
module req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_din;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/alloc_requester.sv
// Requester side of the switch-allocation handshake: per-input destination
// queues, request rows, grant checking and delivery. Optional: STARVE_CNT_EN.
module alloc_requester
    import alloc_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned HOLDOFF = 1
`ifdef STARVE_CNT_EN
    ,
    parameter int unsigned STARVE_LIMIT = 32
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N-1:0]                  push_valid,
    input  logic [N-1:0][$clog2(N)-1:0]   push_dest,
    output logic [N-1:0]                  push_ready,
    output logic [N-1:0][N-1:0]           req,
    input  logic [N-1:0][N-1:0]           gnt,
    output logic [N-1:0]                  deliver_valid,
    output logic [N-1:0][$clog2(N)-1:0]   deliver_dest,
    output logic                          gnt_err
`ifdef STARVE_CNT_EN
    ,
    output logic [N-1:0]                  starve
`endif
);

    localparam int unsigned DW = $clog2(N);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    logic [N-1:0] w_bad_vec;
    logic         w_col_conflict;
    logic         w_seen;
    logic         r_gnt_err;

    for (genvar gi = 0; gi < N; gi++) begin : g_in
        logic [DW-1:0] w_head;
        logic [CW-1:0] w_count;
        logic [CW-1:0] w_count_nxt;
        logic          w_full;
        logic          w_push;
        logic          w_accept;
        logic          w_req_on;
        logic [N-1:0]  w_row;
        req_state_t    r_state;
        logic [HW-1:0] r_hold;
        logic          r_dv;
        logic [DW-1:0] r_dd;

        req_fifo #(.DEPTH(DEPTH), .W(DW)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push),
            .i_din   (push_dest[gi]),
            .i_pop   (w_accept),
            .o_head  (w_head),
            .o_count (w_count),
            .o_full  (w_full)
        );

        assign w_push   = push_valid[gi] & ~w_full;
        assign w_req_on = (r_state == ST_REQ);

        always_comb begin
            w_row = '0;
            if (w_req_on) w_row[w_head] = 1'b1;
        end

        assign w_accept      = w_req_on && (gnt[gi] == w_row);
        assign w_bad_vec[gi] = w_req_on && (gnt[gi] != '0) && (gnt[gi] != w_row);
        assign w_count_nxt   = w_count + CW'(w_push) - CW'(w_accept);

        // ST_REQ is held exactly when the queue is non-empty and holdoff has expired
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_EMPTY;
                r_hold  <= '0;
                r_dv    <= 1'b0;
                r_dd    <= '0;
            end else begin
                r_dv <= w_accept;
                if (w_accept) r_dd <= w_head;
                case (r_state)
                    ST_EMPTY: if (w_push) r_state <= ST_REQ;
                    ST_REQ: begin
                        if (w_accept) begin
                            if (HOLDOFF != 0) begin
                                r_hold  <= HW'(HOLDOFF);
                                r_state <= ST_HOLD;
                            end else begin
                                r_state <= (w_count_nxt != '0) ? ST_REQ : ST_EMPTY;
                            end
                        end
                    end
                    ST_HOLD: begin
                        r_hold <= r_hold - 1'b1;
                        if (r_hold <= HW'(1))
                            r_state <= (w_count_nxt != '0) ? ST_REQ : ST_EMPTY;
                    end
                    default: r_state <= ST_EMPTY;
                endcase
            end
        end

        assign push_ready[gi]    = ~w_full;
        assign req[gi]           = w_row;
        assign deliver_valid[gi] = r_dv;
        assign deliver_dest[gi]  = r_dd;

`ifdef STARVE_CNT_EN
        logic [7:0] r_age;
        always_ff @(posedge clk) begin
            if (reset || w_accept)                r_age <= '0;
            else if (w_req_on && r_age != 8'hFF)  r_age <= r_age + 8'd1;
        end
        assign starve[gi] = (32'(r_age) >= STARVE_LIMIT);
`endif
    end

    always_comb begin
        w_col_conflict = 1'b0;
        w_seen         = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            w_seen = 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                if (gnt[i][j]) begin
                    if (w_seen) w_col_conflict = 1'b1;
                    w_seen = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_gnt_err <= 1'b0;
        else       r_gnt_err <= r_gnt_err | (|w_bad_vec) | w_col_conflict;
    end

    assign gnt_err = r_gnt_err;

endmodule

// File: tb/tb_alloc_requester.sv
// Self-checking bench for alloc_requester against a queue-based reference model.
module tb_alloc_requester;
    import alloc_pkg::*;

    localparam int N       = 4;
    localparam int DEPTH   = 4;
    localparam int HOLDOFF = 1;
    localparam int DW      = 2;

    logic                   clk;
    logic                   reset;
    logic [N-1:0]           push_valid;
    logic [N-1:0][DW-1:0]   push_dest;
    logic [N-1:0]           push_ready;
    logic [N-1:0][N-1:0]    req;
    logic [N-1:0][N-1:0]    gnt;
    logic [N-1:0]           deliver_valid;
    logic [N-1:0][DW-1:0]   deliver_dest;
    logic                   gnt_err;

    alloc_requester #(.N(N), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .clk           (clk),
        .reset         (reset),
        .push_valid    (push_valid),
        .push_dest     (push_dest),
        .push_ready    (push_ready),
        .req           (req),
        .gnt           (gnt),
        .deliver_valid (deliver_valid),
        .deliver_dest  (deliver_dest),
        .gnt_err       (gnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int unsigned          mq [N][$];
    int                   mh [N];
    logic [N-1:0][N-1:0]  exp_req;
    logic [N-1:0]         exp_rdy;
    logic [N-1:0]         exp_dv;
    logic [N-1:0][DW-1:0] exp_dd;
    logic                 exp_err;

    function automatic logic [N-1:0][DW-1:0] dmask(input logic [N-1:0] v);
        logic [N-1:0][DW-1:0] m;
        for (int i = 0; i < N; i++) m[i] = v[i] ? '1 : '0;
        return m;
    endfunction

    task automatic recompute();
        for (int i = 0; i < N; i++) begin
            exp_req[i] = (mq[i].size() > 0 && mh[i] == 0) ? onehot(dest_t'(mq[i][0])) : '0;
            exp_rdy[i] = (mq[i].size() < DEPTH);
        end
    endtask

    // Advance one clock edge and apply the handshake rules to the model.
    task automatic tick();
        logic [N-1:0][N-1:0] r;
        int cnt;
        @(posedge clk);
        r = exp_req;
        if (reset) begin
            for (int i = 0; i < N; i++) begin mq[i].delete(); mh[i] = 0; end
            exp_dv = '0; exp_dd = '0; exp_err = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                logic acc, bad, pushed;
                acc    = (r[i] != '0) && (gnt[i] == r[i]);
                bad    = (r[i] != '0) && (gnt[i] != '0) && (gnt[i] != r[i]);
                pushed = push_valid[i] && (mq[i].size() < DEPTH);
                exp_dv[i] = acc;
                if (bad) exp_err = 1'b1;
                if (acc) begin
                    exp_dd[i] = DW'(mq[i].pop_front());
                    mh[i] = HOLDOFF;
                end else if (mh[i] > 0) begin
                    mh[i]--;
                end
                if (pushed) mq[i].push_back(int'(push_dest[i]));
            end
            for (int j = 0; j < N; j++) begin
                cnt = 0;
                for (int i = 0; i < N; i++) if (gnt[i][j]) cnt++;
                if (cnt > 1) exp_err = 1'b1;
            end
        end
        recompute();
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; push_valid = '0; push_dest = '0; gnt = '0;
        for (int k = 0; k < cycles; k++) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(5);
        tick();
        n_cmp++; if (req !== '0) begin n_bad++; $display("FAIL reset_req got=%h want=0", req); end
        n_cmp++; if (deliver_valid !== '0) begin n_bad++; $display("FAIL reset_dv got=%b want=0", deliver_valid); end
        n_cmp++; if (gnt_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", gnt_err); end
        n_cmp++; if (push_ready !== 4'b1111) begin n_bad++; $display("FAIL reset_rdy got=%b want=1111", push_ready); end
    endtask

    task automatic test_single();
        do_reset(2);
        push_valid = 4'b0001; push_dest[0] = 2'd2;
        tick();
        push_valid = '0;
        n_cmp++; if (req[0] !== 4'b0100) begin n_bad++; $display("FAIL single_req got=%b want=0100", req[0]); end
        gnt[0] = 4'b0100;
        tick();
        gnt = '0;
        n_cmp++; if (deliver_valid !== 4'b0001) begin n_bad++; $display("FAIL single_dv got=%b want=0001", deliver_valid); end
        n_cmp++; if (deliver_dest[0] !== 2'd2) begin n_bad++; $display("FAIL single_dd got=%0d want=2", deliver_dest[0]); end
        n_cmp++; if (req[0] !== 4'b0000) begin n_bad++; $display("FAIL single_req_low got=%b want=0000", req[0]); end
        tick();
        n_cmp++; if (deliver_valid !== '0) begin n_bad++; $display("FAIL single_dv_pulse got=%b want=0000", deliver_valid); end
    endtask

    task automatic test_full();
        int unsigned got[$];
        do_reset(2);
        for (int k = 0; k < 4; k++) begin
            push_valid = 4'b0010; push_dest[1] = DW'(k);
            tick();
        end
        n_cmp++; if (push_ready[1] !== 1'b0) begin n_bad++; $display("FAIL full_rdy got=%b want=0", push_ready[1]); end
        push_dest[1] = 2'd3;
        tick();
        push_valid = '0;
        for (int c = 0; c < 14; c++) begin
            gnt[1] = exp_req[1];
            tick();
            if (deliver_valid[1]) got.push_back(int'(deliver_dest[1]));
            n_cmp++; if (req !== exp_req) begin n_bad++; $display("FAIL full_req got=%h want=%h", req, exp_req); end
        end
        gnt = '0;
        n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL full_count got=%0d want=4", got.size()); end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            n_cmp++; if (got[k] != k) begin n_bad++; $display("FAIL full_order[%0d] got=%0d want=%0d", k, got[k], k); end
        end
    endtask

    task automatic test_arbiter();
        int rr, delivered;
        do_reset(2);
        rr = 0; delivered = 0;
        for (int k = 0; k < 3; k++) begin
            push_valid = '1; push_dest = {N{2'd1}};
            tick();
        end
        push_valid = '0;
        for (int c = 0; c < 40; c++) begin
            gnt = '0;
            for (int k = 0; k < N; k++) begin
                if (req[(rr + k) % N][1]) begin
                    gnt[(rr + k) % N] = 4'b0010;
                    rr = (rr + k + 1) % N;
                    break;
                end
            end
            tick();
            delivered += $countones(deliver_valid);
            n_cmp++; if (deliver_valid !== exp_dv) begin n_bad++; $display("FAIL arb_dv got=%b want=%b", deliver_valid, exp_dv); end
        end
        gnt = '0;
        n_cmp++; if (delivered != 12) begin n_bad++; $display("FAIL arb_total got=%0d want=12", delivered); end
        n_cmp++; if (gnt_err !== 1'b0) begin n_bad++; $display("FAIL arb_err got=%b want=0", gnt_err); end
    endtask

    task automatic test_illegal();
        do_reset(2);
        push_valid = 4'b0100; push_dest[2] = 2'd0;
        tick();
        push_valid = '0;
        n_cmp++; if (req[2] !== 4'b0001) begin n_bad++; $display("FAIL ill_req got=%b want=0001", req[2]); end
        gnt[2] = 4'b0010;
        tick();
        gnt = '0;
        n_cmp++; if (deliver_valid !== '0) begin n_bad++; $display("FAIL ill_dv got=%b want=0000", deliver_valid); end
        n_cmp++; if (gnt_err !== 1'b1) begin n_bad++; $display("FAIL ill_err got=%b want=1", gnt_err); end
        n_cmp++; if (req[2] !== 4'b0001) begin n_bad++; $display("FAIL ill_nopop got=%b want=0001", req[2]); end
        for (int c = 0; c < 3; c++) tick();
        n_cmp++; if (gnt_err !== 1'b1) begin n_bad++; $display("FAIL ill_sticky got=%b want=1", gnt_err); end
        do_reset(1);
        tick();
        n_cmp++; if (gnt_err !== 1'b0) begin n_bad++; $display("FAIL ill_clear got=%b want=0", gnt_err); end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            push_valid = 4'b1000; push_dest[3] = DW'(k + 1);
            tick();
        end
        push_valid = '0;
        reset = 1'b1; gnt[3] = exp_req[3];
        tick();
        reset = 1'b0; gnt = '0;
        n_cmp++; if (req !== '0) begin n_bad++; $display("FAIL mid_req got=%h want=0", req); end
        n_cmp++; if (deliver_valid !== '0) begin n_bad++; $display("FAIL mid_dv got=%b want=0", deliver_valid); end
        n_cmp++; if (push_ready !== 4'b1111) begin n_bad++; $display("FAIL mid_rdy got=%b want=1111", push_ready); end
        tick(); tick();
        n_cmp++; if (req !== '0 || deliver_valid !== '0) begin
            n_bad++; $display("FAIL mid_idle got=%h/%b want=0/0", req, deliver_valid);
        end
    endtask

    task automatic test_random();
        int sel;
        do_reset(2);
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                push_valid[i] = ($urandom_range(0, 2) == 0);
                push_dest[i]  = DW'($urandom_range(0, N - 1));
                sel = $urandom_range(0, 19);
                if (sel < 12)      gnt[i] = exp_req[i];
                else if (sel < 19) gnt[i] = '0;
                else               gnt[i] = N'($urandom_range(0, 15));
            end
            tick();
            n_cmp++; if (req !== exp_req) begin n_bad++; $display("FAIL rnd_req c=%0d got=%h want=%h", c, req, exp_req); end
            n_cmp++; if (push_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_rdy c=%0d got=%b want=%b", c, push_ready, exp_rdy); end
            n_cmp++; if (deliver_valid !== exp_dv) begin n_bad++; $display("FAIL rnd_dv c=%0d got=%b want=%b", c, deliver_valid, exp_dv); end
            n_cmp++; if ((deliver_dest & dmask(exp_dv)) !== (exp_dd & dmask(exp_dv))) begin
                n_bad++; $display("FAIL rnd_dd c=%0d got=%h want=%h", c, deliver_dest & dmask(exp_dv), exp_dd & dmask(exp_dv));
            end
            n_cmp++; if (gnt_err !== exp_err) begin n_bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, gnt_err, exp_err); end
        end
        reset = 1'b0; push_valid = '0; gnt = '0;
    endtask

    initial begin
        reset = 1'b1; push_valid = '0; push_dest = '0; gnt = '0;
        for (int i = 0; i < N; i++) mh[i] = 0;
        exp_dv = '0; exp_dd = '0; exp_err = 1'b0;
        recompute();
        test_reset();
        test_single();
        test_full();
        test_arbiter();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
